// File: rtl/vga_params_pkg.sv
// vga_params: timing constants and decoder FSM encoding shared by the VGA
// timing generator (vga_sync) and the sync decoder (vga_sync_decoder).
// Default figures describe 640x480@60 with a 100 MHz system clock and a
// 25 MHz pixel rate (DIV = 4).
package vga_params;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_DIV       = 4;

    // Line/frame totals and the counter value at which the active area starts.
    // Counters run from the start of the sync pulse, so sync and back porch
    // come first.
    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_ACT   = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_ACT   = DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        H_ALIGN = 2'd1,
        V_ALIGN = 2'd2,
        LOCKED  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/sync_edge_detector.sv
// sync_edge_detector: brings an asynchronous active-low sync signal into the
// clk domain through a two-flop synchronizer and flags its falling edge.
//   clk     in  system clock
//   reset   in  asynchronous active-low reset
//   sync_in in  raw sync input (idle high)
//   fall    out one-clk pulse, two clocks after the input falls
module sync_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic fall
);

    logic meta_p0;
    logic stable_p1;
    logic stable_p2;

    // Flops preset high so that an idle (high) sync line never produces a
    // spurious edge on reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_p0   <= 1'b1;
            stable_p1 <= 1'b1;
            stable_p2 <= 1'b1;
        end else begin
            meta_p0   <= sync_in;
            stable_p1 <= meta_p0;
            stable_p2 <= stable_p1;
        end
    end

    assign fall = stable_p2 & ~stable_p1;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel timing from external hsync/vsync, locks
// onto the raster and reports the current active-area pixel.
//   clk, reset            system clock, asynchronous active-low reset
//   hsync, vsync          active-low syncs from the timing source
//   err_clr               one-clk pulse clearing h_err / v_err
//   pixel_x, pixel_y      active-area coordinate (0 outside the active area)
//   video_on              locked and inside the active area
//   p_tick                recovered pixel tick, one clk every DIV clk
//   locked                FSM is in LOCKED
//   frame_start           one clk with the first active pixel (0,0) of a frame
//   h_err, v_err          sticky line / frame length errors raised while locked
module vga_sync_decoder
    import vga_params::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int DIV       = DEF_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       err_clr,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       p_tick,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT     = 10'(H_SYNC + H_BP);
    localparam logic [9:0]       H_ACT_END = 10'(H_SYNC + H_BP + H_DISPLAY - 1);
    localparam logic [9:0]       V_ACT     = 10'(V_SYNC + V_BP);
    localparam logic [9:0]       V_ACT_END = 10'(V_SYNC + V_BP + V_DISPLAY - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

    logic             h_fall;
    logic             v_fall;
    logic [DIV_W-1:0] div_p0;
    logic [9:0]       h_cnt_p0;
    logic [9:0]       v_cnt_p0;
    dec_state_t       state;
    dec_state_t       state_nx;
    logic             good_seen;
    logic             good_seen_nx;
    logic             set_h;
    logic             set_v;
    logic             line_good;
    logic             line_bad;
    logic             h_wrap;
    logic             frame_bad;
    logic             in_active;
    logic             is_locked;

    sync_edge_detector u_hsync_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_in(hsync),
        .fall   (h_fall)
    );

    sync_edge_detector u_vsync_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_in(vsync),
        .fall   (v_fall)
    );

    // ---- stage p0: pixel divider and raster counters ----
    // An hsync fall re-phases the divider so the tick lands on the pixel
    // boundary of the source; in steady state it coincides with a tick anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_p0 <= '0;
        end else if (h_fall || div_p0 == DIV_LAST) begin
            div_p0 <= '0;
        end else begin
            div_p0 <= div_p0 + DIV_W'(1);
        end
    end

    assign p_tick = (div_p0 == DIV_LAST);

    // Rows advance at the start of the active part of the line, so a row
    // number is stable for every active pixel of that row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else begin
            if (h_fall) begin
                h_cnt_p0 <= '0;
            end else if (p_tick) begin
                h_cnt_p0 <= (h_cnt_p0 == H_LAST) ? 10'd0 : h_cnt_p0 + 10'd1;
            end
            if (v_fall) begin
                v_cnt_p0 <= '0;
            end else if (p_tick && !h_fall && h_cnt_p0 == H_ACT - 10'd1) begin
                v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 10'd0 : v_cnt_p0 + 10'd1;
            end
        end
    end

    // Line/frame qualification. A wrap is the tick where the next hsync fall
    // should have arrived but did not.
    assign line_good = h_fall && (h_cnt_p0 == H_LAST);
    assign line_bad  = h_fall && (h_cnt_p0 != H_LAST);
    assign h_wrap    = p_tick && !h_fall && (h_cnt_p0 == H_LAST);
    assign frame_bad = v_fall && !(v_cnt_p0 == V_LAST || v_cnt_p0 == 10'd0);

    // ---- lock FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            good_seen <= 1'b0;
            h_err     <= 1'b0;
            v_err     <= 1'b0;
        end else begin
            state     <= state_nx;
            good_seen <= good_seen_nx;
            // A new error in the same clock as err_clr survives.
            if (set_h) begin
                h_err <= 1'b1;
            end else if (err_clr) begin
                h_err <= 1'b0;
            end
            if (set_v) begin
                v_err <= 1'b1;
            end else if (err_clr) begin
                v_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        good_seen_nx = good_seen;
        set_h        = 1'b0;
        set_v        = 1'b0;
        unique case (state)
            SEARCH: begin
                // The first edge only establishes line phase; its length is unknown.
                if (h_fall) begin
                    state_nx     = H_ALIGN;
                    good_seen_nx = 1'b0;
                end
            end
            H_ALIGN: begin
                if (line_bad || h_wrap) begin
                    good_seen_nx = 1'b0;
                end else if (line_good) begin
                    if (good_seen) begin
                        state_nx     = V_ALIGN;
                        good_seen_nx = 1'b0;
                    end else begin
                        good_seen_nx = 1'b1;
                    end
                end
            end
            V_ALIGN: begin
                if (line_bad || h_wrap) begin
                    state_nx     = H_ALIGN;
                    good_seen_nx = 1'b0;
                end else if (v_fall) begin
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || h_wrap) begin
                    state_nx = SEARCH;
                    set_h    = 1'b1;
                end
                if (frame_bad) begin
                    state_nx = SEARCH;
                    set_v    = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    assign is_locked = (state == LOCKED);
    assign locked    = is_locked;
    assign in_active = (h_cnt_p0 >= H_ACT) && (h_cnt_p0 <= H_ACT_END) &&
                       (v_cnt_p0 >= V_ACT) && (v_cnt_p0 <= V_ACT_END);

    // ---- stage p1: registered pixel outputs ----
    // frame_start marks the first clock of pixel (0,0), i.e. the clock right
    // after the tick that moved the counters there (divider back at 0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= is_locked && in_active;
            pixel_x     <= (is_locked && in_active) ? h_cnt_p0 - H_ACT : 10'd0;
            pixel_y     <= (is_locked && in_active) ? v_cnt_p0 - V_ACT : 10'd0;
            frame_start <= is_locked && in_active && (h_cnt_p0 == H_ACT) &&
                           (v_cnt_p0 == V_ACT) && (div_p0 == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with a reduced raster (16 x 11 counts, DIV 2)
// so each frame is 352 clocks. A behavioural timing source inside the bench
// drives hsync/vsync and can shorten a line, mask or inject syncs.
module tb_vga_sync_decoder;

    localparam int H_DISPLAY = 8;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 3;
    localparam int H_BP      = 3;
    localparam int V_DISPLAY = 6;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    localparam int DIV       = 2;
    localparam int HT        = H_DISPLAY + H_FP + H_SYNC + H_BP;  // 16
    localparam int VT        = V_DISPLAY + V_FP + V_SYNC + V_BP;  // 11
    localparam int HA        = H_SYNC + H_BP;                     // 6
    localparam int VA        = V_SYNC + V_BP;                     // 4
    localparam int FRAME_CLK = HT * DIV * VT;                     // 352
    localparam int LOCK_MAX  = 2 * FRAME_CLK + HT * DIV;          // 736

    localparam int O_LOCK = 0;
    localparam int O_HERR = 1;
    localparam int O_VERR = 2;
    localparam int O_FS   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       err_clr;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       p_tick;
    logic       locked;
    logic       frame_start;
    logic       h_err;
    logic       v_err;

    int total = 0;
    int bad   = 0;

    // source model state
    int sh, sv, sdiv;
    bit short_line, hs_mask, vs_mask, vs_force;

    vga_sync_decoder #(
        .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DIV(DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .err_clr    (err_clr),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .p_tick     (p_tick),
        .locked     (locked),
        .frame_start(frame_start),
        .h_err      (h_err),
        .v_err      (v_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance the source by one clock at the falling edge. The row counter
    // moves at the start of the active part of the line, so vsync falls at
    // horizontal count HA.
    task automatic run_clk();
        @(negedge clk);
        if (sdiv == DIV - 1) begin
            sdiv = 0;
            if (sh == HT - 1 || (short_line && sh == HT - 2)) begin
                sh = 0;
                short_line = 1'b0;
            end else begin
                sh++;
            end
            if (sh == HA) sv = (sv == VT - 1) ? 0 : sv + 1;
        end else begin
            sdiv++;
        end
        hsync = hs_mask ? 1'b1 : (sh >= H_SYNC);
        vsync = vs_force ? 1'b0 : (vs_mask ? 1'b1 : (sv >= V_SYNC));
    endtask

    function automatic int out_val(input int which);
        case (which)
            O_LOCK:  return int'(locked);
            O_HERR:  return int'(h_err);
            O_VERR:  return int'(v_err);
            default: return int'(frame_start);
        endcase
    endfunction

    task automatic wait_out(input int which, input int want, input int budget, input string name);
        int n = 0;
        while (out_val(which) != want && n < budget) begin
            run_clk();
            n++;
        end
        chk(name, out_val(which), want);
    endtask

    // Wait for the first clock of source pixel (x,y); y < 0 matches any row.
    task automatic wait_src(input int x, input int y, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 2 * FRAME_CLK) begin
            run_clk();
            n++;
            hit = (sh == x) && (y < 0 || sv == y) && (sdiv == 0);
        end
        chk(name, int'(hit), 1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        run_clk();
        err_clr = 1'b0;
    endtask

    typedef struct {
        int sh;
        int sv;
        int exp_x;
        int exp_y;
        int exp_vo;
    } probe_t;

    probe_t probes[10];

    initial begin
        int n;
        int cnt;

        probes[0] = '{6, 4, 0, 0, 1};   // first active pixel
        probes[1] = '{13, 4, 7, 0, 1};  // last pixel of first row
        probes[2] = '{9, 6, 3, 2, 1};   // probe pixel, three frames in a row
        probes[3] = '{9, 6, 3, 2, 1};
        probes[4] = '{9, 6, 3, 2, 1};
        probes[5] = '{13, 9, 7, 5, 1};  // last active pixel
        probes[6] = '{14, 9, 0, 0, 0};  // horizontal front porch
        probes[7] = '{5, 7, 0, 0, 0};   // horizontal back porch
        probes[8] = '{10, 2, 0, 0, 0};  // vertical back porch rows
        probes[9] = '{6, 10, 0, 0, 0};  // vertical front porch row

        sh = H_SYNC + 1;
        sv = 3;
        sdiv = 0;
        short_line = 1'b0;
        hs_mask = 1'b0;
        vs_mask = 1'b0;
        vs_force = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        err_clr = 1'b0;
        reset = 1'b0;

        // reset state
        repeat (5) run_clk();
        chk("rst locked", int'(locked), 0);
        chk("rst video_on", int'(video_on), 0);
        chk("rst p_tick", int'(p_tick), 0);
        chk("rst frame_start", int'(frame_start), 0);
        chk("rst pixel_x", int'(pixel_x), 0);
        chk("rst pixel_y", int'(pixel_y), 0);
        chk("rst errs", int'({h_err, v_err}), 0);
        reset = 1'b1;

        // acquisition
        wait_out(O_LOCK, 1, LOCK_MAX, "initial lock");

        // p_tick cadence while locked
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            run_clk();
            cnt += int'(p_tick);
        end
        chk("p_tick count in 20 clk", cnt, 20 / DIV);

        // frame_start position, width and period
        wait_out(O_FS, 1, FRAME_CLK + 10, "frame_start seen");
        chk("fs video_on", int'(video_on), 1);
        chk("fs pixel", int'({pixel_x, pixel_y}), 0);
        run_clk();
        chk("fs width", int'(frame_start), 0);
        for (int k = 0; k < 2; k++) begin
            n = 1;
            while (!frame_start && n < 2 * FRAME_CLK) begin
                run_clk();
                n++;
            end
            chk("frame period", n, FRAME_CLK);
            run_clk();
        end

        // pixel probes: outputs lag the source pixel by 4 clocks
        for (int i = 0; i < 10; i++) begin
            wait_src(probes[i].sh, probes[i].sv, "probe reached");
            repeat (4) run_clk();
            chk("probe pixel_x", int'(pixel_x), probes[i].exp_x);
            chk("probe pixel_y", int'(pixel_y), probes[i].exp_y);
            chk("probe video_on", int'(video_on), probes[i].exp_vo);
        end
        chk("still locked after probes", int'(locked), 1);

        // one line short by one pixel
        wait_src(HA, 3, "short line start");
        short_line = 1'b1;
        wait_out(O_HERR, 1, HT * DIV + 10, "short line h_err");
        chk("short line unlock", int'(locked), 0);
        wait_out(O_LOCK, 1, LOCK_MAX, "relock after short line");
        chk("h_err held", int'(h_err), 1);
        pulse_clr();
        chk("h_err cleared", int'(h_err), 0);

        // vsync suppressed for one frame: counter wrap keeps lock
        wait_src(HA, 5, "vsync mask start");
        vs_mask = 1'b1;
        cnt = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            run_clk();
            cnt += int'(!locked);
        end
        vs_mask = 1'b0;
        chk("lost lock while vsync masked", cnt, 0);
        chk("v_err after masked vsync", int'(v_err), 0);

        // vsync injected mid-frame
        wait_src(HA + 2, 6, "vsync inject point");
        vs_force = 1'b1;
        repeat (HT * DIV) run_clk();
        vs_force = 1'b0;
        chk("inject v_err", int'(v_err), 1);
        chk("inject unlock", int'(locked), 0);
        chk("inject h_err", int'(h_err), 0);
        wait_out(O_LOCK, 1, LOCK_MAX, "relock after inject");
        pulse_clr();
        chk("v_err cleared", int'(v_err), 0);

        // hsync held high for two lines, err_clr on the wrap clock
        wait_src(H_SYNC + 1, -1, "hsync mask start");
        hs_mask = 1'b1;
        wait_src(0, -1, "missing hsync");
        repeat (2) run_clk();
        err_clr = 1'b1;
        run_clk();
        err_clr = 1'b0;
        chk("wrap h_err over err_clr", int'(h_err), 1);
        chk("wrap unlock", int'(locked), 0);
        wait_src(H_SYNC + 1, -1, "mask line 1");
        wait_src(H_SYNC + 1, -1, "mask line 2");
        hs_mask = 1'b0;
        wait_out(O_LOCK, 1, LOCK_MAX, "relock after wrap");

        // reset mid-frame
        wait_src(10, 5, "reset point");
        reset = 1'b0;
        #1;
        chk("reset outputs", int'({pixel_x, pixel_y, video_on, p_tick, locked,
                                   frame_start, h_err, v_err}), 0);
        repeat (3) run_clk();
        reset = 1'b1;
        wait_src(0, VT - 1, "before next vsync");
        chk("no lock before vsync", int'(locked), 0);
        wait_out(O_LOCK, 1, LOCK_MAX, "relock after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
